// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch sequencer with buffered decode handshake and branch redirect; FETCH_PERF_COUNTERS_EN adds fetch/stall counters
package common_pkg;
  localparam int INSTRUCTION_MEMORY_ADDRESS_WIDTH = 8;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int RISC_V_DATA_WIDTH = 32;
endpackage

module fetch_controller import common_pkg::*; #(
  parameter int BUFFER_DEPTH = 2,
  parameter int IMAW = INSTRUCTION_MEMORY_ADDRESS_WIDTH,
  parameter int IW = INSTRUCTION_WIDTH,
  parameter int DW = RISC_V_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic [IMAW-1:0]      instruction_address,
  input  logic [IW-1:0]        instruction_data,
  input  logic                 ctrl_branch,
  input  logic                 ALU_zero_flag,
  input  logic [IMAW-1:0]      branch_pc,
  input  logic signed [DW-1:0] offset,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW-1:0]        out_instruction,
  output logic [IMAW-1:0]      out_pc,
  output logic                 busy
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]          fetch_count,
  output logic [31:0]          stall_count
`endif
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(BUFFER_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t r_state, w_next;
  logic [IMAW-1:0] r_pc;
  logic [IMAW-1:0] r_mem_pc [BUFFER_DEPTH];
  logic [IW-1:0] r_mem_ins [BUFFER_DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_count;
  logic w_taken, w_pop, w_push, w_unused;
  assign w_unused = ^offset[DW-1:IMAW];
  assign w_taken = ctrl_branch & ALU_zero_flag;
  assign out_valid = r_count != '0;
  assign w_pop = out_valid & out_ready;
  assign w_push = (r_state == RUN) & enable & ~w_taken & ((r_count != FULL) | w_pop);
  assign instruction_address = r_pc;
  assign out_instruction = out_valid ? r_mem_ins[r_rd] : '0;
  assign out_pc = out_valid ? r_mem_pc[r_rd] : '0;
  assign busy = (r_state != IDLE) | out_valid;
  always_comb begin
    w_next = IDLE;
    w_next = w_taken ? ((r_state == IDLE) ? IDLE : FLUSH) : (enable ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc <= '0;
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_taken) begin
        r_pc <= branch_pc + offset[IMAW-1:0];
        r_rd <= '0;
        r_wr <= '0;
        r_count <= '0;
      end else begin
        r_pc <= w_push ? r_pc + IMAW'(1) : r_pc;
        r_wr <= w_push ? r_wr + AW'(1) : r_wr;
        r_rd <= w_pop ? r_rd + AW'(1) : r_rd;
        r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr] <= r_pc;
      r_mem_ins[r_wr] <= instruction_data;
    end
  end
`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      fetch_count <= fetch_count + 32'(w_push & ~&fetch_count);
      stall_count <= stall_count + 32'(out_valid & ~out_ready & ~&stall_count);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: queue-model and directed-vector bench for fetch_controller
module tb_fetch_controller;
  import common_pkg::*;
  localparam int IMAW = INSTRUCTION_MEMORY_ADDRESS_WIDTH;
  localparam int IW = INSTRUCTION_WIDTH;
  localparam int DW = RISC_V_DATA_WIDTH;
  localparam int DEPTH = 2;
  localparam logic [IMAW-1:0] TOP = {IMAW{1'b1}};
  logic clk = 0, rst = 1, enable = 0, ctrl_branch = 0, ALU_zero_flag = 0, out_ready = 0;
  logic [IMAW-1:0] instruction_address, out_pc;
  logic [IMAW-1:0] branch_pc = '0;
  logic [IW-1:0] instruction_data, out_instruction;
  logic signed [DW-1:0] offset = '0;
  logic out_valid, busy;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count, stall_count;
`endif
  assign instruction_data = 32'h1000_0000 | IW'(instruction_address);
  always #5 clk = ~clk;
  fetch_controller #(.BUFFER_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .instruction_address(instruction_address),
    .instruction_data(instruction_data),
    .ctrl_branch(ctrl_branch),
    .ALU_zero_flag(ALU_zero_flag),
    .branch_pc(branch_pc),
    .offset(offset),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instruction(out_instruction),
    .out_pc(out_pc),
    .busy(busy)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [IMAW-1:0] m_q[$];
  logic [IMAW-1:0] m_pc, m_head;
  int m_mode;
  bit m_live = 0, m_taken, m_pop, m_push;
  longint m_fetch, m_stall;
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_pc = '0;
      m_mode = 0;
      m_fetch = 0;
      m_stall = 0;
      m_live = 1;
    end else begin
      m_taken = ctrl_branch && ALU_zero_flag;
      m_pop = m_q.size() > 0 && out_ready;
      m_push = m_mode == 1 && enable && !m_taken && (m_q.size() < DEPTH || m_pop);
      if (m_q.size() > 0 && !out_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (m_push && m_fetch < 64'hFFFF_FFFF) m_fetch++;
      if (m_pop) void'(m_q.pop_front());
      if (m_taken) begin
        m_q.delete();
        m_pc = branch_pc + offset[IMAW-1:0];
        m_mode = (m_mode == 0) ? 0 : 2;
      end else begin
        if (m_push) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 1'b1;
        end
        m_mode = enable ? 1 : 0;
      end
    end
  end
  always @(negedge clk) begin
    if (m_live) begin
      m_head = '0;
      if (m_q.size() > 0) m_head = m_q[0];
      chk("address", instruction_address, m_pc);
      chk("out_valid", out_valid, m_q.size() > 0);
      chk("out_pc", out_pc, m_head);
      chk("out_instruction", out_instruction, (m_q.size() > 0) ? (64'h1000_0000 | m_head) : 64'h0);
      chk("busy", busy, m_mode != 0 || m_q.size() > 0);
`ifdef FETCH_PERF_COUNTERS_EN
      chk("fetch_count", fetch_count, m_fetch);
      chk("stall_count", stall_count, m_stall);
`endif
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick;
    tick;
    chk("lit_rst_valid", out_valid, 0);
    chk("lit_rst_addr", instruction_address, 0);
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_ins", out_instruction, 0);
    rst = 0;
    enable = 1;
    out_ready = 1;
    tick;
    tick;
    chk("lit_c2_valid", out_valid, 1);
    chk("lit_c2_pc", out_pc, 0);
    tick;
    chk("lit_c3_pc", out_pc, 1);
    tick;
    chk("lit_c4_pc", out_pc, 2);
    tick;
    chk("lit_c5_pc", out_pc, 3);
    chk("lit_c5_ins", out_instruction, 32'h1000_0003);
    chk("lit_c5_busy", busy, 1);
    out_ready = 0;
    repeat (5) tick;
    chk("lit_stall_pc", out_pc, 3);
    chk("lit_stall_addr", instruction_address, 5);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("lit_stall_count", stall_count, 5);
`endif
    out_ready = 1;
    tick;
    chk("lit_drain_pc4", out_pc, 4);
    tick;
    chk("lit_drain_pc5", out_pc, 5);
    ctrl_branch = 1;
    ALU_zero_flag = 1;
    branch_pc = 4;
    offset = -2;
    tick;
    ctrl_branch = 0;
    ALU_zero_flag = 0;
    chk("lit_br_n1_valid", out_valid, 0);
    chk("lit_br_n1_addr", instruction_address, 2);
    tick;
    chk("lit_br_n2_valid", out_valid, 0);
    tick;
    chk("lit_br_n3_valid", out_valid, 1);
    chk("lit_br_n3_pc", out_pc, 2);
    ctrl_branch = 1;
    branch_pc = 99;
    offset = 5;
    tick;
    ctrl_branch = 0;
    chk("lit_untaken_pc", out_pc, 3);
    chk("lit_untaken_addr", instruction_address, 4);
    ctrl_branch = 1;
    ALU_zero_flag = 1;
    branch_pc = TOP;
    offset = 1;
    tick;
    chk("lit_wrap_target", instruction_address, 0);
    branch_pc = 0;
    offset = -6;
    tick;
    ctrl_branch = 0;
    ALU_zero_flag = 0;
    chk("lit_neg_target", instruction_address, TOP - 5);
    repeat (7) tick;
    chk("lit_pc_wrap_addr", instruction_address, 0);
    chk("lit_pc_wrap_head", out_pc, TOP);
    out_ready = 0;
    repeat (3) tick;
    chk("lit_full_valid", out_valid, 1);
    rst = 1;
    tick;
    rst = 0;
    chk("lit_mid_rst_valid", out_valid, 0);
    chk("lit_mid_rst_addr", instruction_address, 0);
    chk("lit_mid_rst_busy", busy, 0);
    repeat (3) tick;
    chk("lit_refill_pc", out_pc, 0);
    chk("lit_refill_addr", instruction_address, 2);
    enable = 0;
    out_ready = 1;
    tick;
    chk("lit_dis_busy", busy, 1);
    chk("lit_dis_pc", out_pc, 1);
    tick;
    chk("lit_dis_empty", out_valid, 0);
    chk("lit_dis_idle", busy, 0);
    chk("lit_dis_addr", instruction_address, 2);
    enable = 1;
    tick;
    tick;
    chk("lit_resume_valid", out_valid, 1);
    chk("lit_resume_pc", out_pc, 2);
    repeat (4) tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
